simple_dual_port_sync_sram: RTL and testbench

SIMPLE_DUAL_PORT_SYNC_SRAM -- requirements
Module: simple_dual_port_sync_sram

---
 rtl/sdp_sram_pkg.sv | 14 +
 rtl/sdp_sram_clear_ctrl.sv | 62 ++++++
 rtl/simple_dual_port_sync_sram.sv | 93 +++++++++
 tb/tb_simple_dual_port_sync_sram.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_sram_pkg.sv
// Shared types and helpers for the simple dual-port SRAM.
// Optional feature in the top: SDP_SRAM_BYPASS_EN (write-first same-address read).
package sdp_sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sdp_sram_clear_ctrl.sv
// Zero-fill sweep controller: walks one address per cycle after reset or clr.
module sdp_sram_clear_ctrl
  import sdp_sram_pkg::*;
#(
  parameter  int D  = 64,
  localparam int AW = addr_w(D)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  output logic          busy_o,
  output logic          sweep_we_o,
  output logic [AW-1:0] sweep_addr_o
);

  localparam logic [AW-1:0] LAST = AW'(D - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o       = (state_q == CLEAR);
  assign sweep_we_o   = (state_q == CLEAR);
  assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/simple_dual_port_sync_sram.sv
// Simple dual-port synchronous SRAM with byte enables and a zero-fill sweep.
// Define SDP_SRAM_BYPASS_EN for write-first same-address reads (default read-first).
module simple_dual_port_sync_sram
  import sdp_sram_pkg::*;
#(
  parameter  int W  = 32,
  parameter  int D  = 64,
  localparam int AW = addr_w(D)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            w_en,
  input  logic [AW-1:0]   w_addr,
  input  logic [W/8-1:0]  w_be,
  input  logic [W-1:0]    w_data,
  input  logic            r_en,
  input  logic [AW-1:0]   r_addr,
  output logic [W-1:0]    r_data,
  output logic            r_valid,
  output logic            busy
);

  localparam int          NB    = W / 8;
  localparam logic [AW:0] DEPTH = (AW + 1)'(D);

  logic [W-1:0]  mem [D];
  logic          sweep_we;
  logic [AW-1:0] sweep_addr;
  logic          w_ok, r_ok, w_acc, r_acc;
  logic [W-1:0]  rd_word;
  logic [W-1:0]  r_data_q, r_data_d;
  logic          r_valid_q, r_valid_d;

  sdp_sram_clear_ctrl #(.D(D)) u_clear_ctrl (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (clr),
    .busy_o       (busy),
    .sweep_we_o   (sweep_we),
    .sweep_addr_o (sweep_addr)
  );

  assign w_ok  = ({1'b0, w_addr} < DEPTH);
  assign r_ok  = ({1'b0, r_addr} < DEPTH);
  // clr wins over user traffic in the same cycle
  assign w_acc = w_en & ~busy & ~clr & w_ok;
  assign r_acc = r_en & ~busy & ~clr;

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (w_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) mem[w_addr][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (r_ok) begin
      rd_word = mem[r_addr];
`ifdef SDP_SRAM_BYPASS_EN
      if (w_acc && (w_addr == r_addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (w_be[b]) rd_word[8*b +: 8] = w_data[8*b +: 8];
        end
      end
`endif
    end
  end

  always_comb begin
    r_data_d  = r_data_q;
    r_valid_d = r_acc;
    if (r_acc) r_data_d = rd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;

endmodule

// File: tb/tb_simple_dual_port_sync_sram.sv
// Directed bench: D=64 instance for main function, D=48 instance for out-of-range addressing.
module tb_simple_dual_port_sync_sram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_clr, a_w_en, a_r_en, a_r_valid, a_busy;
  logic [5:0]  a_w_addr, a_r_addr;
  logic [3:0]  a_w_be;
  logic [31:0] a_w_data, a_r_data;

  logic        b_clr, b_w_en, b_r_en, b_r_valid, b_busy;
  logic [5:0]  b_w_addr, b_r_addr;
  logic [3:0]  b_w_be;
  logic [31:0] b_w_data, b_r_data;

  int checks = 0;
  int failures = 0;

  simple_dual_port_sync_sram #(.W(32), .D(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr),
    .w_en(a_w_en), .w_addr(a_w_addr), .w_be(a_w_be), .w_data(a_w_data),
    .r_en(a_r_en), .r_addr(a_r_addr),
    .r_data(a_r_data), .r_valid(a_r_valid), .busy(a_busy)
  );

  simple_dual_port_sync_sram #(.W(32), .D(48)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr),
    .w_en(b_w_en), .w_addr(b_w_addr), .w_be(b_w_be), .w_data(b_w_data),
    .r_en(b_r_en), .r_addr(b_r_addr),
    .r_data(b_r_data), .r_valid(b_r_valid), .busy(b_busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int na, nb;
    logic [5:0] addrs [3];
    addrs[0] = 6'd0; addrs[1] = 6'd5; addrs[2] = 6'd63;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (a_busy !== 1'b1 || a_r_valid !== 1'b0 || a_r_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: busy=%b r_valid=%b r_data=%h, need 1 0 00000000", a_busy, a_r_valid, a_r_data);
    end
    rst_n = 1'b1;
    na = 0; nb = 0;
    for (int i = 0; i < 200 && (a_busy || b_busy); i++) begin
      if (a_busy) na++;
      if (b_busy) nb++;
      tick();
    end
    checks++;
    if (na != 64) begin
      failures++;
      $display("FAIL sweep_len_d64: got %0d cycles, need 64", na);
    end
    checks++;
    if (nb != 48) begin
      failures++;
      $display("FAIL sweep_len_d48: got %0d cycles, need 48", nb);
    end
    // back-to-back reads after the sweep
    a_r_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_r_addr = addrs[k];
      tick();
      checks++;
      if (a_r_valid !== 1'b1 || a_r_data !== 32'h0) begin
        failures++;
        $display("FAIL post_sweep_read[%0d]: r_valid=%b r_data=%h, need 1 00000000", addrs[k], a_r_valid, a_r_data);
      end
    end
    a_r_en = 1'b0;
    tick();
  endtask

  task automatic test_byte_enable();
    a_w_en = 1'b1; a_w_addr = 6'd5; a_w_be = 4'hF; a_w_data = 32'hDEADBEEF;
    tick();
    a_w_be = 4'b0010; a_w_data = 32'h00001100;
    tick();
    a_w_be = 4'b0000; a_w_data = 32'hFFFFFFFF;
    tick();
    a_w_en = 1'b0;
    a_r_en = 1'b1; a_r_addr = 6'd5;
    tick();
    a_r_en = 1'b0;
    checks++;
    if (a_r_valid !== 1'b1 || a_r_data !== 32'hDEAD11EF) begin
      failures++;
      $display("FAIL byte_enable: r_valid=%b r_data=%h, need 1 DEAD11EF", a_r_valid, a_r_data);
    end
    tick();
    checks++;
    if (a_r_valid !== 1'b0 || a_r_data !== 32'hDEAD11EF) begin
      failures++;
      $display("FAIL read_hold: r_valid=%b r_data=%h, need 0 DEAD11EF", a_r_valid, a_r_data);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_full, exp_part;
`ifdef SDP_SRAM_BYPASS_EN
    exp_full = 32'h12345678;
    exp_part = 32'hDEAD11AA;
`else
    exp_full = 32'h00000000;
    exp_part = 32'hDEAD11EF;
`endif
    a_w_en = 1'b1; a_w_addr = 6'd9; a_w_be = 4'hF; a_w_data = 32'h12345678;
    a_r_en = 1'b1; a_r_addr = 6'd9;
    tick();
    checks++;
    if (a_r_valid !== 1'b1 || a_r_data !== exp_full) begin
      failures++;
      $display("FAIL same_cycle_full: r_valid=%b r_data=%h, need 1 %h", a_r_valid, a_r_data, exp_full);
    end
    a_w_addr = 6'd5; a_w_be = 4'b0001; a_w_data = 32'h000000AA;
    a_r_addr = 6'd5;
    tick();
    checks++;
    if (a_r_data !== exp_part) begin
      failures++;
      $display("FAIL same_cycle_partial: r_data=%h, need %h", a_r_data, exp_part);
    end
    a_w_en = 1'b0;
    a_r_addr = 6'd9;
    tick();
    a_r_en = 1'b0;
    checks++;
    if (a_r_data !== 32'h12345678) begin
      failures++;
      $display("FAIL same_cycle_stored: r_data=%h, need 12345678", a_r_data);
    end
  endtask

  task automatic test_clear_ignore();
    int n;
    bit leak;
    a_w_en = 1'b1; a_w_addr = 6'd3; a_w_be = 4'hF; a_w_data = 32'hA5A5A5A5;
    tick();
    a_w_en = 1'b0; a_r_en = 1'b1; a_r_addr = 6'd3;
    tick();
    a_r_en = 1'b0;
    tick();
    checks++;
    if (a_r_valid !== 1'b0 || a_r_data !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL idle_ready: r_valid=%b r_data=%h, need 0 A5A5A5A5", a_r_valid, a_r_data);
    end
    // clr together with a read: the read must not be accepted
    a_clr = 1'b1; a_r_en = 1'b1; a_r_addr = 6'd5;
    tick();
    a_clr = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_r_valid !== 1'b0 || a_r_data !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL clr_priority: busy=%b r_valid=%b r_data=%h, need 1 0 A5A5A5A5", a_busy, a_r_valid, a_r_data);
    end
    a_w_en = 1'b1; a_w_addr = 6'd3; a_w_data = 32'hFFFFFFFF;
    leak = 1'b0;
    repeat (30) begin
      tick();
      if (a_r_valid !== 1'b0 || a_r_data !== 32'hA5A5A5A5) leak = 1'b1;
    end
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && a_busy; i++) begin
      n++;
      if (a_r_valid !== 1'b0 || a_r_data !== 32'hA5A5A5A5) leak = 1'b1;
      tick();
    end
    checks++;
    if (leak) begin
      failures++;
      $display("FAIL read_in_clear: r_valid/r_data changed during sweep, need 0 and A5A5A5A5 held");
    end
    checks++;
    if (n != 64) begin
      failures++;
      $display("FAIL clr_restart_len: got %0d busy cycles, need 64", n);
    end
    a_w_en = 1'b0;
    a_r_addr = 6'd3;
    tick();
    checks++;
    if (a_r_valid !== 1'b1 || a_r_data !== 32'h0) begin
      failures++;
      $display("FAIL cleared_addr3: r_valid=%b r_data=%h, need 1 00000000", a_r_valid, a_r_data);
    end
    a_r_addr = 6'd9;
    tick();
    checks++;
    if (a_r_valid !== 1'b1 || a_r_data !== 32'h0) begin
      failures++;
      $display("FAIL cleared_addr9: r_valid=%b r_data=%h, need 1 00000000", a_r_valid, a_r_data);
    end
    a_r_en = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    b_w_en = 1'b1; b_w_be = 4'hF; b_w_addr = 6'd47; b_w_data = 32'h11223344;
    tick();
    b_w_addr = 6'd50; b_w_data = 32'hFFFFFFFF;
    tick();
    b_w_en = 1'b0;
    b_r_en = 1'b1; b_r_addr = 6'd47;
    tick();
    checks++;
    if (b_r_valid !== 1'b1 || b_r_data !== 32'h11223344) begin
      failures++;
      $display("FAIL oob_neighbor47: r_valid=%b r_data=%h, need 1 11223344", b_r_valid, b_r_data);
    end
    b_r_addr = 6'd50;
    tick();
    checks++;
    if (b_r_valid !== 1'b1 || b_r_data !== 32'h0) begin
      failures++;
      $display("FAIL oob_read50: r_valid=%b r_data=%h, need 1 00000000", b_r_valid, b_r_data);
    end
    b_r_addr = 6'd2;
    tick();
    b_r_en = 1'b0;
    checks++;
    if (b_r_valid !== 1'b1 || b_r_data !== 32'h0) begin
      failures++;
      $display("FAIL oob_alias2: r_valid=%b r_data=%h, need 1 00000000", b_r_valid, b_r_data);
    end
    tick();
  endtask

  initial begin
    a_clr = 1'b0; a_w_en = 1'b0; a_w_addr = '0; a_w_be = '0; a_w_data = '0;
    a_r_en = 1'b0; a_r_addr = '0;
    b_clr = 1'b0; b_w_en = 1'b0; b_w_addr = '0; b_w_be = '0; b_w_data = '0;
    b_r_en = 1'b0; b_r_addr = '0;
    test_reset();
    test_byte_enable();
    test_same_cycle();
    test_clear_ignore();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
